// File: rtl/phys_reg_free_list_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phys_reg_free_list_pkg
// Description : Shared sizing constants and the physical tag type used by the
//               free list, rename and the reorder buffer.
// Revision    : 1.0  initial release
// ============================================================================
package phys_reg_free_list_pkg;

    localparam int NUM_PHYS = 64;
    localparam int NUM_ARCH = 32;
    localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH;
    localparam int TAG_W    = $clog2(NUM_PHYS);
    localparam int PTR_W    = $clog2(FL_DEPTH);
    localparam int CNT_W    = $clog2(FL_DEPTH) + 1;

    typedef logic [TAG_W-1:0] tag_t;

    // Tag 0 is the permanent x0 mapping and doubles as "no tag" on free ports.
    localparam tag_t TAG_NONE = '0;

endpackage : phys_reg_free_list_pkg
`default_nettype wire

// File: rtl/phys_reg_free_list_tag_bitmap_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tag_bitmap_tracker
// Description : One bit per physical tag marking membership in the free list;
//               used to catch duplicate frees.
// Revision    : 1.0  initial release
// ============================================================================
module tag_bitmap_tracker
    import phys_reg_free_list_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                alloc_fire,
    input  logic [TAG_W-1:0]    alloc_tag,
    input  logic                set_1_en,
    input  logic [TAG_W-1:0]    set_1_tag,
    input  logic                set_2_en,
    input  logic [TAG_W-1:0]    set_2_tag,
    output logic [NUM_PHYS-1:0] in_list
);

    localparam logic [NUM_PHYS-1:0] c_reset_map =
        {{(NUM_PHYS-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};

    logic [NUM_PHYS-1:0] r_in_list;
    logic [NUM_PHYS-1:0] w_in_list_next;

    always_comb begin
        w_in_list_next = r_in_list;
        if (alloc_fire)
            w_in_list_next[alloc_tag] = 1'b0;
        if (set_1_en)
            w_in_list_next[set_1_tag] = 1'b1;
        if (set_2_en)
            w_in_list_next[set_2_tag] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_in_list <= c_reset_map;
        else
            r_in_list <= w_in_list_next;
    end

    assign in_list = r_in_list;

endmodule : tag_bitmap_tracker
`default_nettype wire

// File: rtl/phys_reg_free_list.sv
`default_nettype none
// ============================================================================
// Module      : phys_reg_free_list
// Description : Circular FIFO of free physical register tags; one allocation
//               and up to two frees per cycle. FREELIST_DUP_CHECK_EN adds
//               duplicate-free detection via tag_bitmap_tracker.
// Revision    : 1.0  initial release
// ============================================================================
module phys_reg_free_list
    import phys_reg_free_list_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_req,
    output logic             alloc_valid,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic [TAG_W-1:0] free_1_tag,
    input  logic [TAG_W-1:0] free_2_tag,
    output logic [CNT_W-1:0] free_count,
    output logic             overflow_err,
    output logic             dup_free_err
);

    tag_t             r_entry [FL_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic             w_alloc_fire;
    logic             w_f1;
    logic             w_f2;
    logic             w_dup1;
    logic             w_dup2;
    logic             w_cand1;
    logic             w_cand2;
    logic             w_acc1;
    logic             w_acc2;
    logic             w_drop;
    logic [CNT_W-1:0] w_count_less;
    logic [CNT_W-1:0] w_space;
    logic [PTR_W-1:0] w_tail_2;

    assign alloc_valid  = (r_count != '0);
    assign alloc_tag    = r_entry[r_head];
    assign w_alloc_fire = alloc_req & alloc_valid;

    assign w_f1 = (free_1_tag != TAG_NONE);
    assign w_f2 = (free_2_tag != TAG_NONE);

`ifdef FREELIST_DUP_CHECK_EN
    logic [NUM_PHYS-1:0] w_in_list;
    logic                r_dup_err;

    tag_bitmap_tracker u_tag_bitmap_tracker (
        .clk        (clk),
        .reset      (reset),
        .alloc_fire (w_alloc_fire),
        .alloc_tag  (alloc_tag),
        .set_1_en   (w_acc1),
        .set_1_tag  (free_1_tag),
        .set_2_en   (w_acc2),
        .set_2_tag  (free_2_tag),
        .in_list    (w_in_list)
    );

    assign w_dup1 = w_f1 & w_in_list[free_1_tag];
    assign w_dup2 = w_f2 & (w_in_list[free_2_tag] |
                            (w_f1 & (free_1_tag == free_2_tag)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_dup_err <= 1'b0;
        else if (w_dup1 | w_dup2)
            r_dup_err <= 1'b1;
    end

    assign dup_free_err = r_dup_err;
`else
    assign w_dup1       = 1'b0;
    assign w_dup2       = 1'b0;
    assign dup_free_err = 1'b0;
`endif

    assign w_cand1 = w_f1 & ~w_dup1;
    assign w_cand2 = w_f2 & ~w_dup2;

    // Space counts the slot vacated by a same-cycle allocation.
    assign w_count_less = r_count - CNT_W'(w_alloc_fire);
    assign w_space      = CNT_W'(FL_DEPTH) - w_count_less;

    assign w_acc1   = w_cand1 & (w_space != '0);
    assign w_acc2   = w_cand2 & (w_space > CNT_W'(w_acc1));
    assign w_drop   = (w_cand1 & ~w_acc1) | (w_cand2 & ~w_acc2);
    assign w_tail_2 = r_tail + PTR_W'(w_acc1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++)
                r_entry[i] <= TAG_W'(NUM_ARCH + i);
        end else begin
            if (w_acc1)
                r_entry[r_tail] <= free_1_tag;
            if (w_acc2)
                r_entry[w_tail_2] <= free_2_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= CNT_W'(FL_DEPTH);
            r_overflow <= 1'b0;
        end else begin
            r_head     <= r_head + PTR_W'(w_alloc_fire);
            r_tail     <= r_tail + PTR_W'(w_acc1) + PTR_W'(w_acc2);
            r_count    <= w_count_less + CNT_W'(w_acc1) + CNT_W'(w_acc2);
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    assign free_count   = r_count;
    assign overflow_err = r_overflow;

endmodule : phys_reg_free_list
`default_nettype wire
